// File: rtl/psum_align_fifo.sv
// rtl/psum_align_fifo.sv - per-column partial-sum FIFOs that release only fully aligned rows
// Optional sticky overflow flag o_ovf is built when PSUM_ALIGN_OVF_EN is defined.
module psum_align_fifo #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready
`ifdef PSUM_ALIGN_OVF_EN
  ,
  output logic                   o_ovf
`endif
);

  localparam int aw = $clog2(depth);
  localparam logic [aw:0] depth_cnt = (aw+1)'(depth);

  logic [psum_bw-1:0]     mem  [col][depth];
  logic [aw-1:0]          wptr [col];
  logic [aw-1:0]          rptr [col];
  logic [aw:0]            cnt  [col];

  logic [psum_bw*col-1:0] in_clean;
  logic [col-1:0]         lane_empty;
  logic [col-1:0]         lane_full;
  logic [col-1:0]         wr_acc;
  logic                   rd_acc;

  // Unknown input bits are forced to 0 before storage.
  always_comb begin
    in_clean = '0;
    for (int b = 0; b < psum_bw*col; b++) begin
      in_clean[b] = (in[b] === 1'b1);
    end
  end

  always_comb begin
    lane_empty = '0;
    lane_full  = '0;
    for (int k = 0; k < col; k++) begin
      lane_empty[k] = (cnt[k] == '0);
      lane_full[k]  = (cnt[k] == depth_cnt);
    end
  end

  assign o_valid = ~|lane_empty;
  assign rd_acc  = rd & o_valid;
  // A full lane still takes a write when the same edge pops its head.
  assign wr_acc  = wr & (~lane_full | {col{rd_acc}});
  assign o_full  = |lane_full;
  assign o_ready = ~o_full;

  always_comb begin
    out = '0;
    for (int k = 0; k < col; k++) begin
      if (!lane_empty[k]) begin
        out[psum_bw*k +: psum_bw] = mem[k][rptr[k]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < col; k++) begin
        wptr[k] <= '0;
        rptr[k] <= '0;
        cnt[k]  <= '0;
        for (int d = 0; d < depth; d++) begin
          mem[k][d] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < col; k++) begin
        if (wr_acc[k]) begin
          mem[k][wptr[k]] <= in_clean[psum_bw*k +: psum_bw];
          wptr[k]         <= wptr[k] + 1'b1;
        end
        if (rd_acc) begin
          rptr[k] <= rptr[k] + 1'b1;
        end
        case ({wr_acc[k], rd_acc})
          2'b10:   cnt[k] <= cnt[k] + 1'b1;
          2'b01:   cnt[k] <= cnt[k] - 1'b1;
          default: cnt[k] <= cnt[k];
        endcase
      end
    end
  end

`ifdef PSUM_ALIGN_OVF_EN
  logic drop_any;

  assign drop_any = |(wr & lane_full & ~{col{rd_acc}});

  always_ff @(posedge clk) begin
    if (reset) begin
      o_ovf <= 1'b0;
    end else if (drop_any) begin
      o_ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_psum_align_fifo.sv
// tb/tb_psum_align_fifo.sv - directed self-checking bench for psum_align_fifo
module tb_psum_align_fifo;

  localparam int COL = 8;
  localparam int BW  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [BW*COL-1:0] in;
  logic [COL-1:0]    wr;
  logic              rd;
  logic [BW*COL-1:0] out;
  logic              o_valid;
  logic              o_full;
  logic              o_ready;
`ifdef PSUM_ALIGN_OVF_EN
  logic              o_ovf;
`endif

  int total = 0;
  int bad   = 0;

  psum_align_fifo #(.col(COL), .psum_bw(BW), .depth(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in),
    .wr      (wr),
    .rd      (rd),
    .out     (out),
    .o_valid (o_valid),
    .o_full  (o_full),
    .o_ready (o_ready)
`ifdef PSUM_ALIGN_OVF_EN
    ,
    .o_ovf   (o_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; wr = '0; rd = 1'b0; in = '0;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [BW*COL-1:0] wrap_row(input int i);
    logic [BW*COL-1:0] r;
    for (int k = 0; k < COL; k++) begin
      if (i == 3)       r[BW*k +: BW] = 16'hFFFF;
      else if (i == 11) r[BW*k +: BW] = 16'h8000;
      else if (i == 15) r[BW*k +: BW] = (k % 2 == 0) ? 16'hFFFF : 16'h8000;
      else              r[BW*k +: BW] = 16'(i * 1000 + k * 37);
    end
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1; wr = '1; rd = 1'b1; in = '1;
    tick(); tick();
    reset = 1'b0; wr = '0; rd = 1'b0; in = '0;
    tick();
    total++; if (out !== '0) begin bad++; $display("FAIL reset_out got %h exp 0", out); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b exp 0", o_valid); end
    total++; if (o_full !== 1'b0) begin bad++; $display("FAIL reset_full got %b exp 0", o_full); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b exp 1", o_ready); end
`ifdef PSUM_ALIGN_OVF_EN
    total++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got %b exp 0", o_ovf); end
`endif
  endtask

  task automatic test_skew();
    logic [BW*COL-1:0] exp_row;
    do_reset();
    for (int k = 0; k < COL; k++) begin
      exp_row[BW*k +: BW] = 16'(100 + k);
      in = {COL{16'hDEAD}};
      in[BW*k +: BW] = 16'(100 + k);
      wr = '0;
      wr[k] = 1'b1;
      tick();
      if (k < COL - 1) begin
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL skew_valid_early k=%0d got %b exp 0", k, o_valid); end
      end
    end
    wr = '0;
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL skew_valid got %b exp 1", o_valid); end
    total++; if (out !== exp_row) begin bad++; $display("FAIL skew_out got %h exp %h", out, exp_row); end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL skew_pop_valid got %b exp 0", o_valid); end
    total++; if (out !== '0) begin bad++; $display("FAIL skew_pop_out got %h exp 0", out); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int v = 1; v <= 9; v++) begin
      in = '0;
      in[BW-1:0] = 16'(v);
      wr = 8'h01;
      tick();
      if (v == 7) begin
        total++; if (o_full !== 1'b0) begin bad++; $display("FAIL fill_full7 got %b exp 0", o_full); end
      end
      if (v == 8) begin
        total++; if (o_full !== 1'b1) begin bad++; $display("FAIL fill_full8 got %b exp 1", o_full); end
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL fill_ready8 got %b exp 0", o_ready); end
`ifdef PSUM_ALIGN_OVF_EN
        total++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL fill_ovf8 got %b exp 0", o_ovf); end
`endif
      end
    end
    wr = '0;
    tick();
    total++; if (o_full !== 1'b1) begin bad++; $display("FAIL fill_full9 got %b exp 1", o_full); end
    total++; if (out[BW-1:0] !== 16'd1) begin bad++; $display("FAIL fill_head got %h exp 0001", out[BW-1:0]); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL fill_valid got %b exp 0", o_valid); end
`ifdef PSUM_ALIGN_OVF_EN
    total++; if (o_ovf !== 1'b1) begin bad++; $display("FAIL fill_ovf got %b exp 1", o_ovf); end
    tick();
    total++; if (o_ovf !== 1'b1) begin bad++; $display("FAIL fill_ovf_sticky got %b exp 1", o_ovf); end
`endif
  endtask

  task automatic test_bypass();
    logic [BW*COL-1:0] exp_row;
    logic [BW*COL-1:0] new_row;
    do_reset();
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < COL; k++) in[BW*k +: BW] = 16'(r * 16 + k + 1);
      wr = '1;
      tick();
    end
    total++; if (o_full !== 1'b1) begin bad++; $display("FAIL bypass_pre_full got %b exp 1", o_full); end
    for (int k = 0; k < COL; k++) new_row[BW*k +: BW] = 16'(16'hA000 + k);
    in = new_row; wr = '1; rd = 1'b1;
    tick();
    wr = '0; rd = 1'b0;
    for (int k = 0; k < COL; k++) exp_row[BW*k +: BW] = 16'(16 + k + 1);
    total++; if (out !== exp_row) begin bad++; $display("FAIL bypass_head got %h exp %h", out, exp_row); end
    total++; if (o_full !== 1'b1) begin bad++; $display("FAIL bypass_full got %b exp 1", o_full); end
`ifdef PSUM_ALIGN_OVF_EN
    total++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL bypass_ovf got %b exp 0", o_ovf); end
`endif
    rd = 1'b1;
    for (int p = 0; p < 7; p++) tick();
    rd = 1'b0;
    total++; if (out !== new_row) begin bad++; $display("FAIL bypass_tail got %h exp %h", out, new_row); end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL bypass_drain got %b exp 0", o_valid); end
  endtask

  task automatic test_wrap();
    logic [BW*COL-1:0] exp_row;
    do_reset();
    in = wrap_row(0); wr = '1;
    tick();
    for (int i = 1; i < 20; i++) begin
      in = wrap_row(i); wr = '1; rd = 1'b1;
      tick();
      exp_row = wrap_row(i);
      total++; if (out !== exp_row) begin bad++; $display("FAIL wrap_row%0d got %h exp %h", i, out, exp_row); end
    end
    wr = '0; rd = 1'b1;
    tick();
    rd = 1'b0;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL wrap_drain got %b exp 0", o_valid); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int r = 0; r < 3; r++) begin
      in = {COL{16'(16'h0550 + r)}}; wr = '1;
      tick();
    end
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got %b exp 1", o_valid); end
    reset = 1'b1; wr = '1; rd = 1'b1; in = {COL{16'h7777}};
    tick();
    reset = 1'b0; wr = '0; rd = 1'b0;
    total++; if (out !== '0) begin bad++; $display("FAIL mid_out got %h exp 0", out); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got %b exp 0", o_valid); end
    total++; if (o_full !== 1'b0) begin bad++; $display("FAIL mid_full got %b exp 0", o_full); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got %b exp 1", o_ready); end
    in = '0; in[BW-1:0] = 16'h0042; wr = 8'h01;
    tick();
    wr = '0;
    total++; if (out !== {{(BW*(COL-1)){1'b0}}, 16'h0042}) begin bad++; $display("FAIL mid_fresh got %h exp 42", out); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL mid_fresh_valid got %b exp 0", o_valid); end
  endtask

  initial begin
    reset = 1'b1; wr = '0; rd = 1'b0; in = '0;
    test_reset();
    test_skew();
    test_fill();
    test_bypass();
    test_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
